// File: rtl/dm_sort_checker.sv
// Data-memory sort checker: on fetch PC reaching HALT_PC, reads NUM_WORDS words from
// BASE_ADDR and verifies strict signed ascending order. Optional DMCHK_SUM_EN adds a word sum.
module dm_sort_checker #(
    parameter logic [31:0] HALT_PC   = 32'd92,
    parameter logic [31:0] BASE_ADDR = 32'd512,
    parameter int          NUM_WORDS = 12,
    parameter int          IDX_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    output logic             dm_rd,
    output logic [31:0]      dm_addr,
    input  logic [31:0]      dm_rdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IDX_W-1:0] fail_idx
`ifdef DMCHK_SUM_EN
    ,
    output logic [31:0]      sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);

    state_t           state_q;
    logic             dm_rd_q;
    logic [31:0]      dm_addr_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [IDX_W-1:0] fail_idx_q;
    logic [IDX_W-1:0] issue_q;
    logic [IDX_W-1:0] cap_q;
    logic             vld_p1_q;
    logic signed [31:0] prev_p1_q;

    logic signed [31:0] word_p0;
    logic             cap_en_d;
    logic             cap_fail_d;
    logic             cap_last_d;

    // Stage p0 -> p1: returned word is judged against the previously captured word
    assign word_p0    = $signed(dm_rdata);
    assign cap_en_d   = vld_p1_q && ((state_q == S_SCAN) || (state_q == S_DRAIN));
    assign cap_fail_d = cap_en_d && (cap_q != '0) && !(word_p0 > prev_p1_q);
    assign cap_last_d = cap_en_d && (cap_q == LAST) && !cap_fail_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            dm_rd_q    <= 1'b0;
            dm_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
            issue_q    <= '0;
            cap_q      <= '0;
            vld_p1_q   <= 1'b0;
        end else begin
            vld_p1_q <= dm_rd_q;
            case (state_q)
                S_IDLE: begin
                    if (pc == HALT_PC) begin
                        state_q   <= S_SCAN;
                        dm_rd_q   <= 1'b1;
                        dm_addr_q <= BASE_ADDR;
                        busy_q    <= 1'b1;
                        issue_q   <= '0;
                        cap_q     <= '0;
                    end
                end
                S_SCAN, S_DRAIN: begin
                    if (state_q == S_SCAN && !cap_fail_d) begin
                        if (issue_q == LAST) begin
                            dm_rd_q <= 1'b0;
                            state_q <= S_DRAIN;
                        end else begin
                            issue_q   <= issue_q + 1'b1;
                            dm_addr_q <= dm_addr_q + 32'd4;
                        end
                    end
                    if (cap_en_d) begin
                        cap_q <= cap_q + 1'b1;
                    end
                    // First out-of-order word ends the scan; reads still in flight are dropped
                    if (cap_fail_d) begin
                        state_q    <= S_DONE;
                        dm_rd_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        fail_idx_q <= cap_q;
                    end else if (cap_last_d) begin
                        state_q <= S_DONE;
                        dm_rd_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en_d) begin
            prev_p1_q <= word_p0;
        end
    end

`ifdef DMCHK_SUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
        end else if (cap_en_d) begin
            sum_q <= sum_q + dm_rdata;
        end
    end

    assign sum = sum_q;
`endif

    assign dm_rd    = dm_rd_q;
    assign dm_addr  = dm_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_idx = fail_idx_q;

endmodule
